// File: rtl/td4_pkg.sv
// Shared TD4 definitions: loader FSM states and program-memory geometry.
package td4_pkg;

  localparam int TD4_PROG_DEPTH = 16;
  localparam int TD4_ADDR_W     = 4;
  localparam int TD4_DATA_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } td4_state_t;

  function automatic logic [TD4_DATA_W-1:0] csum_add(
    input logic [TD4_DATA_W-1:0] a,
    input logic [TD4_DATA_W-1:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/td4_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, followed by a registered
// rising-edge detector producing a one-cycle pulse.
module td4_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain plus the previous-level flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= (r_sync << 1) | SYNC_STAGES'(i_async);
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/td4_prog_loader.sv
// Host-driven program loader for the TD4 core: writes DEPTH bytes into program
// memory, verifies a trailing modulo-256 checksum, and releases the CPU on success.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int DEPTH       = TD4_PROG_DEPTH,
  parameter int SYNC_STAGES = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  wr_stb,
  input  logic [TD4_DATA_W-1:0] wr_data,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [TD4_DATA_W-1:0] mem_wdata,
  output logic                  cpu_run,
  output logic                  busy,
  output logic                  err,
  output logic [TD4_DATA_W-1:0] csum
);

  logic w_ld_level;
  logic w_ld_rise;
  logic w_stb_level;
  logic w_stb_rise;

  td4_state_t            r_state;
  logic [AW-1:0]         r_cnt;
  logic [TD4_DATA_W-1:0] r_csum;
  logic                  r_we;
  logic [AW-1:0]         r_addr;
  logic [TD4_DATA_W-1:0] r_wdata;
  logic                  r_run;
  logic                  r_busy;
  logic                  r_err;

  td4_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ld (
    .clk     (clk),
    .rst     (rst),
    .i_async (load_en),
    .o_level (w_ld_level),
    .o_rise  (w_ld_rise)
  );

  td4_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stb (
    .clk     (clk),
    .rst     (rst),
    .i_async (wr_stb),
    .o_level (w_stb_level),
    .o_rise  (w_stb_rise)
  );

  // Loader FSM with counter, checksum accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_csum  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_run   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          // Load-enable edges take priority; strobes here are simply dropped.
          if (w_ld_rise) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_csum  <= '0;
            r_run   <= 1'b0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!w_ld_level) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_csum  <= '0;
            r_busy  <= 1'b0;
          end else if (w_stb_rise) begin
            r_we    <= 1'b1;
            r_addr  <= r_cnt;
            r_wdata <= wr_data;
            r_csum  <= csum_add(r_csum, wr_data);
            r_cnt   <= r_cnt + AW'(1);
            if (r_cnt == AW'(DEPTH - 1)) begin
              r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (!w_ld_level) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_csum  <= '0;
            r_busy  <= 1'b0;
          end else if (w_stb_rise) begin
            r_busy <= 1'b0;
            if (wr_data == r_csum) begin
              r_state <= ST_RUN;
              r_run   <= 1'b1;
            end else begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_csum  <= '0;
          r_run   <= 1'b0;
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_run   = r_run;
  assign busy      = r_busy;
  assign err       = r_err;
  assign csum      = r_csum;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Self-checking bench for td4_prog_loader: an abstract load/checksum model
// predicts writes and status, one monitor compares every meaningful cycle.
module tb_td4_prog_loader;

  localparam int S = 2;
  localparam int M_IDLE = 0, M_LOAD = 1, M_CHECK = 2, M_RUN = 3, M_ERR = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_en = 1'b0;
  logic       wr_stb = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic       busy;
  logic       err;
  logic [7:0] csum;

  td4_prog_loader #(.DEPTH(16), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .wr_stb    (wr_stb),
    .wr_data   (wr_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .err       (err),
    .csum      (csum)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int sum; } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int m_mode = M_IDLE;
  int m_cnt = 0;
  int m_sum = 0;
  bit settled = 1'b0;
  int last_addr = -1;
  int last_data = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reset values, every write against the model, and settled status.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outs", {mem_we, mem_addr, mem_wdata, cpu_run, busy, err, csum}, 0);
    end else begin
      if (mem_we) begin
        last_addr = mem_addr;
        last_data = mem_wdata;
        if (exp_q.size() == 0) begin
          chk("unexpected_we", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
          chk("wr_csum", csum, e.sum);
        end
      end
      if (settled) begin
        chk("cpu_run", cpu_run, int'(m_mode == M_RUN));
        chk("busy", busy, int'(m_mode == M_LOAD || m_mode == M_CHECK));
        chk("err", err, int'(m_mode == M_ERR));
        chk("csum", csum, m_sum);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive_load(input logic v);
    step(1);
    load_en = v;
    settled = 1'b0;
    if (v && (m_mode == M_IDLE || m_mode == M_RUN || m_mode == M_ERR)) begin
      m_mode = M_LOAD; m_cnt = 0; m_sum = 0;
    end else if (!v && (m_mode == M_LOAD || m_mode == M_CHECK)) begin
      m_mode = M_IDLE; m_cnt = 0; m_sum = 0;
    end
    step(S + 2);
    settled = 1'b1;
  endtask

  task automatic strobe(input logic [7:0] b);
    int exp_we;
    step(1);
    wr_stb = 1'b1;
    wr_data = b;
    settled = 1'b0;
    exp_we = int'(m_mode == M_LOAD);
    if (m_mode == M_LOAD) begin
      m_sum = (m_sum + b) % 256;
      exp_q.push_back('{addr: m_cnt, data: b, sum: m_sum});
      m_cnt++;
      if (m_cnt == 16) begin
        m_cnt = 0; m_mode = M_CHECK;
      end
    end else if (m_mode == M_CHECK) begin
      m_mode = (b == m_sum) ? M_RUN : M_ERR;
    end
    step(S);
    chk("we_early", mem_we, 0);
    step(1);
    chk("we_latency", mem_we, exp_we);
    step(2);
    wr_stb = 1'b0;
    step(S + 2);
    settled = 1'b1;
  endtask

  task automatic load16;
    for (int i = 0; i < 16; i++) strobe(8'(i));
  endtask

  initial begin
    // Reset with pins toggling.
    for (int i = 0; i < 6; i++) begin
      step(1);
      load_en = ~load_en;
      wr_stb = ~wr_stb;
      wr_data = 8'($urandom);
    end
    load_en = 1'b0;
    wr_stb = 1'b0;
    step(S + 2);
    rst = 1'b0;
    step(2);
    settled = 1'b1;
    chk("idle_busy", busy, 0);

    // Good load.
    drive_load(1'b1);
    load16();
    chk("good_csum", csum, 8'h78);
    strobe(8'h78);
    chk("good_run", cpu_run, 1);
    chk("good_busy", busy, 0);
    chk("good_err", err, 0);

    // Bad checksum, then recovery via a fresh load_en edge.
    drive_load(1'b0);
    drive_load(1'b1);
    chk("bad_run_drop", cpu_run, 0);
    load16();
    strobe(8'h77);
    chk("bad_err", err, 1);
    chk("bad_run", cpu_run, 0);
    drive_load(1'b0);
    drive_load(1'b1);
    chk("err_cleared", err, 0);
    chk("reload_busy", busy, 1);

    // Abort after 5 bytes; later strobes are ignored.
    for (int i = 0; i < 5; i++) strobe(8'(8'h10 + i));
    drive_load(1'b0);
    chk("abort_csum", csum, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 3; i++) strobe(8'hEE);

    // Good load, then reload from RUN.
    drive_load(1'b1);
    load16();
    strobe(8'h78);
    chk("run2", cpu_run, 1);
    drive_load(1'b0);
    step(1);
    load_en = 1'b1;
    settled = 1'b0;
    m_mode = M_LOAD; m_cnt = 0; m_sum = 0;
    step(S);
    chk("run_before_edge", cpu_run, 1);
    step(1);
    chk("run_at_load", cpu_run, 0);
    chk("busy_at_load", busy, 1);
    step(1);
    settled = 1'b1;
    strobe(8'h3C);
    chk("reload_addr0", last_addr, 0);

    // Async reset between byte 7 and byte 8.
    for (int i = 1; i < 7; i++) strobe(8'(8'h40 + i));
    chk("pre_rst_addr", last_addr, 6);
    @(posedge clk);
    #3;
    rst = 1'b1;
    settled = 1'b0;
    #1;
    chk("async_rst", {mem_we, mem_addr, mem_wdata, cpu_run, busy, err, csum}, 0);
    m_mode = M_IDLE; m_cnt = 0; m_sum = 0;
    load_en = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);
    settled = 1'b1;
    drive_load(1'b1);
    strobe(8'hA5);
    chk("post_rst_addr", last_addr, 0);
    chk("post_rst_data", last_data, 8'hA5);
    chk("post_rst_csum", csum, 8'hA5);

    step(4);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/td4_prog_loader.md
# td4_prog_loader

Program loader that sits directly upstream of the TD4 CPU core inside the Tiny Tapeout top. It accepts a host-driven byte stream on the user pins: a load-enable level plus a data strobe and 8-bit data. It writes 16 program bytes into the TD4 program memory and verifies a trailing modulo-256 checksum. It releases the CPU to run only after a good load.

## Interface

Parameters:
- `DEPTH`, default 16: number of program bytes per load; must be a power of two.
- `SYNC_STAGES`, default 2: synchronizer flops on each asynchronous pin input, ahead of the edge-detect flop.

Ports:
- `clk`, in, 1: system clock, the same clock that drives the CPU.
- `rst`, in, 1: asynchronous, active-high reset. The top derives it from `rst_n`.
- `load_en`, in, 1: asynchronous pin level. High means the host owns program memory.
- `wr_stb`, in, 1: asynchronous pin strobe. Each rising edge presents one byte.
- `wr_data`, in, 8: byte value. Held stable by the host for the full strobe-high period.
- `mem_we`, out, 1: one-cycle program-memory write pulse.
- `mem_addr`, out, log2(DEPTH): write address.
- `mem_wdata`, out, 8: write data, valid while `mem_we` is high.
- `cpu_run`, out, 1: high releases the CPU from hold. Low keeps PC and registers in reset.
- `busy`, out, 1: high while in LOAD or CHECK.
- `err`, out, 1: checksum mismatch flag.
- `csum`, out, 8: running modulo-256 sum of the bytes written in the current load.

## Operation

- The FSM has five states: IDLE, LOAD, CHECK, RUN, ERROR.
- Reset values: state IDLE; `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `busy`=0, `err`=0, `csum`=0; byte counter 0; all synchronizer flops 0.
- IDLE → LOAD on a synchronized rising edge of `load_en`. On entry, the counter and `csum` clear.
- LOAD: each synchronized `wr_stb` rising edge does the following:
  - Writes `wr_data` to address = counter.
  - Adds the byte to `csum` (8-bit wrap).
  - Increments the counter.
  - After byte DEPTH-1 is written, the FSM moves to CHECK.
- CHECK: the next strobe edge carries the checksum byte and causes no memory write.
  - Byte equals `csum`: go to RUN.
  - Byte differs from `csum`: go to ERROR and set `err`=1.
- RUN: `cpu_run`=1. A synchronized rising edge of `load_en` returns to LOAD. `cpu_run` drops in the same cycle that LOAD is entered.
- ERROR: `cpu_run`=0 and `err`=1. A synchronized `load_en` rising edge enters LOAD and clears `err`.
- Abort: synchronized `load_en` low while in LOAD or CHECK returns to IDLE.
  - Bytes already written stay in memory.
  - The counter and `csum` clear.
  - `cpu_run` stays 0.
- A strobe edge while in IDLE, RUN or ERROR is ignored: no write and no state change.
- If a load-enable edge and a strobe edge arrive in the same cycle, the `load_en` action wins and the strobe is dropped.
- The counter wraps only through the CHECK transition. Addresses never exceed DEPTH-1.

## Timing

- Let N be the first clock edge that samples `wr_stb` high.
  - The synchronized rising-edge pulse is valid in the cycle after edge N+SYNC_STAGES-1.
  - `mem_we`, `mem_addr` and `mem_wdata` are registered. They are high and valid for exactly one cycle after edge N+SYNC_STAGES.
  - Pin-to-write latency is therefore SYNC_STAGES+1 clocks.
- `wr_data` is captured from the pins when the edge pulse is taken, so the host holds it throughout strobe-high.
- Host strobe rules: high for at least SYNC_STAGES+1 clocks; low for at least SYNC_STAGES+1 clocks.
- `load_en` has the same latency. The state change is visible SYNC_STAGES+1 clocks after the pin edge.
- `csum` updates in the same cycle as `mem_we`.
- State moves to RUN or ERROR, with `cpu_run`/`err` updating, one cycle after the checksum edge pulse.
- Asserting `rst` at any point immediately forces all reset values, including mid-LOAD. No write pulse may be emitted in that cycle.

## Structure

- Shared package `td4_pkg` holds:
  - the state enum (IDLE, LOAD, CHECK, RUN, ERROR);
  - `TD4_PROG_DEPTH`=16;
  - `TD4_ADDR_W`=4;
  - `TD4_DATA_W`=8.
- Sub-module `td4_sync_edge`: an N-flop synchronizer plus a registered rising-edge detector. It outputs the synchronized level and a one-cycle rise pulse.
  - It is instantiated twice, once for `load_en` and once for `wr_stb`.
- The top-level loader contains the FSM, counter, checksum accumulator and output registers.

## Test plan

- Reset: assert `rst` with pins toggling → every output is 0, state is IDLE, and no `mem_we` ever appears.
- Good load: raise `load_en`, strobe bytes 0x00..0x0F, then strobe checksum 0x78 → 16 `mem_we` pulses at addr 0..15 with matching data, `csum`=0x78, then `cpu_run`=1, `busy`=0, `err`=0.
- Bad checksum: the same 16 bytes, then checksum 0x77 → `err`=1, `cpu_run`=0. A new `load_en` rising edge clears `err`.
- Abort: drop `load_en` after 5 bytes → state IDLE, `csum`=0, and further strobes produce no `mem_we`.
- Reload from RUN: after a good load, pulse `load_en` low then high → `cpu_run` falls on LOAD entry and the next write goes to addr 0.
- Async reset mid-load: assert `rst` between byte 7 and byte 8 → immediate reset values. The next load restarts at addr 0.
